// File: rtl/mxint_row_max_subtract.sv
// mxint_row_max_subtract: buffers one MXINT row, aligns it to the row max exponent, and subtracts the row max mantissa
module mxint_row_max_subtract #(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_PRECISION_1 = 8,
  parameter int BLOCK_SIZE            = 4,
  parameter int IN_DEPTH              = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] mdata_in_0 [BLOCK_SIZE],
  input  logic [DATA_IN_0_PRECISION_1-1:0] edata_in_0,
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0] mdata_out_0 [BLOCK_SIZE],
  output logic [DATA_IN_0_PRECISION_1-1:0] edata_out_0,
  output logic                             data_out_0_valid,
  input  logic                             data_out_0_ready
);
  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int E  = DATA_IN_0_PRECISION_1;
  localparam int PW = $clog2(IN_DEPTH);
  localparam logic signed [W-1:0] MNEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {FILL, SCAN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [E-1:0]        emax_q, emax_d;
  logic signed [W-1:0] mmax_q, mmax_d;
  logic [W-1:0]        mbuf_q [IN_DEPTH][BLOCK_SIZE];
  logic [E-1:0]        ebuf_q [IN_DEPTH];
  logic signed [W-1:0] aligned [BLOCK_SIZE];
  logic [W:0]          diff [BLOCK_SIZE];
  logic signed [W-1:0] row_max;
  logic [E-1:0]        shift;
  logic                in_fire, out_fire, last, adv;

  assign data_in_0_ready  = state_q == FILL;
  assign data_out_0_valid = state_q == DRAIN;
  assign in_fire          = data_in_0_valid && data_in_0_ready;
  assign out_fire         = data_out_0_valid && data_out_0_ready;
  assign last             = ptr_q == PW'(IN_DEPTH - 1);
  assign adv              = in_fire || state_q == SCAN || out_fire;
  assign shift            = emax_q - ebuf_q[ptr_q];
  assign edata_out_0      = state_q == DRAIN ? emax_q : '0;

  // align the entry under the shared pointer, fold it into the running max, and form saturated differences
  always_comb begin
    row_max = mmax_q;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      aligned[i]     = $signed(mbuf_q[ptr_q][i]) >>> shift;
      row_max        = aligned[i] > row_max ? aligned[i] : row_max;
      diff[i]        = {aligned[i][W-1], aligned[i]} - {mmax_q[W-1], mmax_q};
      mdata_out_0[i] = state_q != DRAIN ? '0 : diff[i][W] != diff[i][W-1] ? MNEG : diff[i][W-1:0];
    end
  end

  // one pointer walks fill, scan and drain in turn since the phases never overlap
  always_comb begin
    ptr_d   = !adv ? ptr_q : last ? '0 : ptr_q + PW'(1);
    state_d = !(adv && last) ? state_q : state_q == FILL ? SCAN : state_q == SCAN ? DRAIN : FILL;
    emax_d  = in_fire && (ptr_q == '0 || edata_in_0 > emax_q) ? edata_in_0 : emax_q;
    mmax_d  = state_q == SCAN ? row_max : out_fire && last ? MNEG : mmax_q;
  end

  // control state and row statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      ptr_q   <= '0;
      emax_q  <= '0;
      mmax_q  <= MNEG;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      emax_q  <= emax_d;
      mmax_q  <= mmax_d;
    end
  end

  // row buffer needs no reset; it is always fully rewritten before being read
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mbuf_q[ptr_q] <= mdata_in_0;
      ebuf_q[ptr_q] <= edata_in_0;
    end
  end
endmodule

// File: tb/tb_mxint_row_max_subtract.sv
// tb_mxint_row_max_subtract: directed and model-checked stimulus for the row max-subtract stage
module tb_mxint_row_max_subtract;
  logic       clk = 0, rst = 1;
  logic [7:0] m_in [2], m_out [2];
  logic [7:0] e_in, e_out;
  logic       vin = 0, rin, vout, rout = 0;
  logic [7:0] b_m_in [4], b_m_out [4];
  logic [7:0] b_e_in, b_e_out;
  logic       b_vin = 0, b_rin, b_vout, b_rout = 0;
  int errors = 0, checks = 0;
  int re [2];
  int rm [2][2];
  int xe;
  int xm [2][2];

  always #5 clk = ~clk;

  mxint_row_max_subtract #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(8), .BLOCK_SIZE(2), .IN_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .mdata_in_0(m_in), .edata_in_0(e_in), .data_in_0_valid(vin), .data_in_0_ready(rin),
    .mdata_out_0(m_out), .edata_out_0(e_out), .data_out_0_valid(vout), .data_out_0_ready(rout));

  mxint_row_max_subtract #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(8), .BLOCK_SIZE(4), .IN_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .mdata_in_0(b_m_in), .edata_in_0(b_e_in), .data_in_0_valid(b_vin), .data_in_0_ready(b_rin),
    .mdata_out_0(b_m_out), .edata_out_0(b_e_out), .data_out_0_valid(b_vout), .data_out_0_ready(b_rout));

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send_blk(input int e, input int x0, input int x1);
    int n = 0;
    @(negedge clk);
    vin = 1; e_in = 8'(e); m_in[0] = 8'(x0); m_in[1] = 8'(x1);
    while (!rin && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", int'(rin), 1);
    @(posedge clk);
    #1 vin = 0;
  endtask

  task automatic recv_blk(input int ee, input int x0, input int x1, input bit rnd);
    int n = 0;
    bit done = 0, seen = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      rout = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vout) begin
        chk("out_m0", int'($signed(m_out[0])), x0);
        chk("out_m1", int'($signed(m_out[1])), x1);
        chk("out_e", int'(e_out), ee);
        chk("in_ready_low", int'(rin), 0);
        seen = 1;
        done = rout;
      end else if (seen) chk("valid_drop", int'(vout), 1);
    end
    if (!done) chk("out_timeout", int'(done), 1);
    @(posedge clk);
    #1 rout = 0;
  endtask

  task automatic model();
    int a [2][2];
    int mx, sh;
    xe = re[0] > re[1] ? re[0] : re[1];
    mx = -1000;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++) begin
        sh = xe - re[k];
        if (sh > 31) sh = 31;
        a[k][i] = rm[k][i] >>> sh;
        if (a[k][i] > mx) mx = a[k][i];
      end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++)
        xm[k][i] = a[k][i] - mx < -128 ? -128 : a[k][i] - mx;
  endtask

  task automatic row_b(input int e, input int m);
    int cnt = 0, n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b_in_ready", int'(b_rin), 1);
      b_vin = 1; b_e_in = 8'(e);
      for (int i = 0; i < 4; i++) b_m_in[i] = 8'(m + k);
      @(posedge clk);
      #1 b_vin = 0;
    end
    b_rout = 1;
    while (cnt < 8 && n < 100) begin
      @(negedge clk);
      n++;
      if (b_vout) begin
        for (int i = 0; i < 4; i++) chk("b_m", int'($signed(b_m_out[i])), (m + k_of(cnt)) - (m + 7));
        chk("b_e", int'(b_e_out), e);
        cnt++;
      end
    end
    chk("b_count", cnt, 8);
    @(negedge clk);
    chk("b_valid_after", int'(b_vout), 0);
    chk("b_ready_after", int'(b_rin), 1);
    b_rout = 0;
  endtask

  function automatic int k_of(input int c);
    return c;
  endfunction

  initial begin
    m_in = '{0, 0}; e_in = 0;
    b_m_in = '{0, 0, 0, 0}; b_e_in = 0;
    #3;
    chk("rst_in_ready", int'(rin), 1);
    chk("rst_out_valid", int'(vout), 0);
    chk("rst_m0", int'(m_out[0]), 0);
    chk("rst_e", int'(e_out), 0);
    @(negedge clk);
    rst = 0;
    send_blk(10, 64, -32);
    send_blk(8, 100, 4);
    @(negedge clk);
    chk("lat_scan0_valid", int'(vout), 0);
    chk("lat_scan0_ready", int'(rin), 0);
    @(negedge clk);
    chk("lat_scan1_valid", int'(vout), 0);
    @(negedge clk);
    chk("lat_drain_valid", int'(vout), 1);
    recv_blk(10, 0, -96, 0);
    recv_blk(10, -39, -63, 0);
    send_blk(5, 127, -128);
    send_blk(5, 0, 0);
    recv_blk(5, 0, -128, 0);
    recv_blk(5, -127, -127, 0);
    send_blk(20, 1, 1);
    send_blk(8, 100, -5);
    recv_blk(20, 0, 0, 0);
    recv_blk(20, -1, -2, 0);
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 2; k++) begin
        re[k] = $urandom_range(0, 30);
        for (int i = 0; i < 2; i++) rm[k][i] = int'($urandom_range(0, 255)) - 128;
      end
      model();
      send_blk(re[0], rm[0][0], rm[0][1]);
      send_blk(re[1], rm[1][0], rm[1][1]);
      recv_blk(xe, xm[0][0], xm[0][1], 1);
      recv_blk(xe, xm[1][0], xm[1][1], 1);
    end
    send_blk(10, 64, -32);
    send_blk(8, 100, 4);
    recv_blk(10, 0, -96, 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("async_rst_valid", int'(vout), 0);
    chk("async_rst_ready", int'(rin), 1);
    chk("async_rst_e", int'(e_out), 0);
    #2 rst = 0;
    send_blk(3, -10, -20);
    send_blk(3, -30, -40);
    recv_blk(3, 0, -10, 0);
    recv_blk(3, -20, -30, 0);
    row_b(9, 37);
    row_b(200, -12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
